// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: one memory-bus link between a requester (master) and a responder (slave)
//   addr   32  byte address            master -> slave
//   rstrb   1  read request/strobe     master -> slave
//   wmask   4  byte write enables      master -> slave
//   wdata  32  write data              master -> slave
//   rdata  32  read data               slave  -> master
//   ack     1  completion pulse        slave  -> master
interface bus_arbiter_if;
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    modport master (output addr, rstrb, wmask, wdata, input rdata, ack);
    modport slave  (input addr, rstrb, wmask, wdata, output rdata, ack);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between two masters and routes each access to RAM or UART
//   clk_i   in   clock, all state on rising edge
//   rst_ni  in   asynchronous reset, active low
//   m0, m1  slave modport    requester links (M0 processor, M1 debug/boot loader)
//   ram     master modport   RAM link, selected when addr[IO_BIT] = 0
//   uart    master modport   UART link, selected when addr[IO_BIT] = 1
//   gnt_o   out  2  one-hot owner of the transaction in flight, 0 when idle
module bus_arbiter #(
    parameter int IO_BIT     = 22,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    bus_arbiter_if.slave         m0,
    bus_arbiter_if.slave         m1,
    bus_arbiter_if.master        ram,
    bus_arbiter_if.master        uart,
    output logic [1:0]           gnt_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    state_t      state, state_nx;
    logic        req0, req1, win, win_nx, last, grant, capture, issue, is_wr, tgt;
    logic [2:0]  cnt, cnt_nx;
    logic [31:0] addr_q, wdata_q, rdata0, rdata1, addr_sel, rdata_sel;
    logic [3:0]  wmask_q;
    logic        unused;

    assign req0 = m0.rstrb | (|m0.wmask);
    assign req1 = m1.rstrb | (|m1.wmask);
    // on a tie the master that did not win last time goes first
    assign win_nx    = (req0 & req1) ? ~last : req1;
    assign addr_sel  = win_nx ? m1.addr : m0.addr;
    assign is_wr     = |wmask_q;
    assign rdata_sel = tgt ? uart.rdata : ram.rdata;
    assign issue     = state == ISSUE;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant    = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                grant    = req0 | req1;
                state_nx = grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                state_nx = is_wr ? ACK : WAIT;
                cnt_nx   = 3'(RD_LATENCY);
            end
            WAIT: begin
                // data is valid in the cycle the count runs out; register it for the ack cycle
                cnt_nx   = cnt - 3'd1;
                capture  = cnt == 3'd1;
                state_nx = capture ? ACK : WAIT;
            end
            ACK: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            win     <= 1'b0;
            last    <= 1'b1;
            tgt     <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (grant) begin
                win     <= win_nx;
                last    <= win_nx;
                addr_q  <= addr_sel;
                tgt     <= addr_sel[IO_BIT];
                wmask_q <= win_nx ? m1.wmask : m0.wmask;
                wdata_q <= win_nx ? m1.wdata : m0.wdata;
            end
            if (capture && !win) rdata0 <= rdata_sel;
            if (capture && win) rdata1 <= rdata_sel;
        end
    end

    // strobes are decoded from state so an async reset drops them at once
    assign ram.rstrb  = issue & ~is_wr & ~tgt;
    assign uart.rstrb = issue & ~is_wr & tgt;
    assign ram.wmask  = (issue & ~tgt) ? wmask_q : 4'b0;
    assign uart.wmask = (issue & tgt) ? wmask_q : 4'b0;
    assign ram.addr   = addr_q;
    assign uart.addr  = addr_q;
    assign ram.wdata  = wdata_q;
    assign uart.wdata = wdata_q;
    assign m0.ack     = (state == ACK) & ~win;
    assign m1.ack     = (state == ACK) & win;
    assign m0.rdata   = rdata0;
    assign m1.rdata   = rdata1;
    assign gnt_o      = (state == IDLE) ? 2'b00 : (win ? 2'b10 : 2'b01);
    // slaves never acknowledge toward the arbiter
    assign unused     = ram.ack ^ uart.ack;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiters (read latency 1 and 3) against a transaction-level model
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    logic [31:0] m_addr[2][2], m_wd[2][2], val[2][2];
    logic        m_rs[2][2];
    logic [3:0]  m_wm[2][2];
    int          rs_cyc[2][2] = '{default: -100};

    wire [1:0]  d_gnt[2];
    wire        ack_w[2][2];
    wire [31:0] d_rd[2][2];
    wire        s_rs[2][2];
    wire [3:0]  s_wm[2][2];
    wire [31:0] s_addr[2][2], s_wd[2][2];

    function automatic int lat(int k);
        return k == 0 ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int L = k == 0 ? 1 : 3;
        bus_arbiter_if m0_if ();
        bus_arbiter_if m1_if ();
        bus_arbiter_if ram_if ();
        bus_arbiter_if uart_if ();
        assign m0_if.addr  = m_addr[k][0];
        assign m0_if.rstrb = m_rs[k][0];
        assign m0_if.wmask = m_wm[k][0];
        assign m0_if.wdata = m_wd[k][0];
        assign m1_if.addr  = m_addr[k][1];
        assign m1_if.rstrb = m_rs[k][1];
        assign m1_if.wmask = m_wm[k][1];
        assign m1_if.wdata = m_wd[k][1];
        // slaves return their stored word only exactly L cycles after rstrb, junk otherwise
        assign ram_if.rdata  = (cyc == rs_cyc[k][0] + L) ? val[k][0] : 32'hBAD0_0000 ^ 32'(cyc);
        assign uart_if.rdata = (cyc == rs_cyc[k][1] + L) ? val[k][1] : 32'hBAD1_0000 ^ 32'(cyc);
        assign ram_if.ack  = 1'b0;
        assign uart_if.ack = 1'b0;
        bus_arbiter #(.IO_BIT(22), .RD_LATENCY(L)) dut (
            .clk_i(clk), .rst_ni(rst_n),
            .m0(m0_if.slave), .m1(m1_if.slave),
            .ram(ram_if.master), .uart(uart_if.master),
            .gnt_o(d_gnt[k])
        );
        assign ack_w[k][0]  = m0_if.ack;
        assign ack_w[k][1]  = m1_if.ack;
        assign d_rd[k][0]   = m0_if.rdata;
        assign d_rd[k][1]   = m1_if.rdata;
        assign s_rs[k][0]   = ram_if.rstrb;
        assign s_rs[k][1]   = uart_if.rstrb;
        assign s_wm[k][0]   = ram_if.wmask;
        assign s_wm[k][1]   = uart_if.wmask;
        assign s_addr[k][0] = ram_if.addr;
        assign s_addr[k][1] = uart_if.addr;
        assign s_wd[k][0]   = ram_if.wdata;
        assign s_wd[k][1]   = uart_if.wdata;
    end

    always @(negedge clk)
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 2; s++)
                if (s_rs[k][s]) rs_cyc[k][s] = cyc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: an access granted in idle cycle T strobes at T+1 and acks at T+2 (write)
    // or T+2+L (read), returning the target's stored word; the bus is idle again after the ack.
    bit          busy[2], wr[2];
    int          c[2], win[2], tgt[2], last[2], ackc;
    logic [31:0] la[2], lwd[2], erd[2][2];
    logic [3:0]  lwm[2];
    bit          iss, r0, r1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy[k] = 0; wr[k] = 0; last[k] = 1; la[k] = 0; lwd[k] = 0; lwm[k] = 0;
                erd[k][0] = 0; erd[k][1] = 0;
            end else if (busy[k]) c[k]++;
            iss  = busy[k] && c[k] == 1;
            ackc = wr[k] ? 2 : 2 + lat(k);
            chk($sformatf("i%0d gnt", k), 32'(d_gnt[k]), busy[k] ? (win[k] == 1 ? 2 : 1) : 0);
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("i%0d s%0d rstrb", k, s), 32'(s_rs[k][s]), 32'(iss && !wr[k] && tgt[k] == s));
                chk($sformatf("i%0d s%0d wmask", k, s), 32'(s_wm[k][s]), (iss && wr[k] && tgt[k] == s) ? 32'(lwm[k]) : 0);
                chk($sformatf("i%0d s%0d addr", k, s), s_addr[k][s], la[k]);
                chk($sformatf("i%0d s%0d wdata", k, s), s_wd[k][s], lwd[k]);
            end
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("i%0d m%0d ack", k, m), 32'(ack_w[k][m]), 32'(busy[k] && c[k] == ackc && win[k] == m));
                chk($sformatf("i%0d m%0d rdata", k, m), d_rd[k][m], erd[k][m]);
            end
            if (busy[k] && !wr[k] && c[k] == 1 + lat(k)) erd[k][win[k]] = val[k][tgt[k]];
            if (busy[k] && c[k] == ackc) busy[k] = 0;
            else if (!busy[k] && rst_n) begin
                r0 = m_rs[k][0] || m_wm[k][0] != 0;
                r1 = m_rs[k][1] || m_wm[k][1] != 0;
                if (r0 || r1) begin
                    win[k]  = (r0 && r1) ? 1 - last[k] : (r1 ? 1 : 0);
                    last[k] = win[k];
                    busy[k] = 1;
                    c[k]    = 0;
                    la[k]   = m_addr[k][win[k]];
                    lwd[k]  = m_wd[k][win[k]];
                    lwm[k]  = m_wm[k][win[k]];
                    wr[k]   = lwm[k] != 0;
                    tgt[k]  = int'(la[k][22]);
                end
            end
        end
    end

    task automatic set_req(int k, int m, logic [31:0] a, logic rs, logic [3:0] wm, logic [31:0] wd);
        m_addr[k][m] = a; m_rs[k][m] = rs; m_wm[k][m] = wm; m_wd[k][m] = wd;
    endtask

    task automatic drop(int k, int m);
        m_rs[k][m] = 0; m_wm[k][m] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // one access on instance k from master m; reports strobe/ack offsets from the request cycle
    task automatic xact(input int k, input int m, input logic [31:0] a, input logic rs,
                        input logic [3:0] wm, input logic [31:0] wd,
                        output int dt_iss, output int dt_ack, output int n_rs,
                        output logic [3:0] wm0, output logic [3:0] wm1, output logic [31:0] wdo);
        int t0;
        @(posedge clk); #1;
        set_req(k, m, a, rs, wm, wd);
        t0 = cyc; dt_iss = -1; dt_ack = -1; n_rs = 0; wm0 = 0; wm1 = 0; wdo = 0;
        for (int i = 0; i < 40 && dt_ack < 0; i++) begin
            @(negedge clk);
            if (s_rs[k][0] || s_rs[k][1]) n_rs++;
            if (dt_iss < 0 && (s_rs[k][0] || s_rs[k][1] || s_wm[k][0] != 0 || s_wm[k][1] != 0)) begin
                dt_iss = cyc - t0;
                wdo = s_wd[k][a[22]];
            end
            wm0 = wm0 | s_wm[k][0];
            wm1 = wm1 | s_wm[k][1];
            if (ack_w[k][m]) dt_ack = cyc - t0;
        end
        if (dt_ack < 0) begin
            checks++; errors++;
            $display("FAIL ack timeout instance %0d master %0d", k, m);
        end
        @(posedge clk); #1;
        drop(k, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int dti, dta, nrs, t0, n, first;
        logic [3:0] w0, w1;
        logic [31:0] wdo;
        rst_n = 0;
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) begin
                set_req(k, m, 0, 0, 0, 0);
                val[k][m] = 0;
            end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // 1: M0 RAM read, latency 1
        val[0][0] = 32'hDEADBEEF;
        xact(0, 0, 32'h0000_0010, 1, 0, 0, dti, dta, nrs, w0, w1, wdo);
        chk("t1 issue", dti, 1);
        chk("t1 ack", dta, 3);
        chk("t1 rdata", d_rd[0][0], 32'hDEADBEEF);
        chk("t1 uart wmask", 32'(w1), 0);

        // 2: M1 UART write
        xact(0, 1, 32'h0040_0008, 0, 4'h1, 32'h41, dti, dta, nrs, w0, w1, wdo);
        chk("t2 issue", dti, 1);
        chk("t2 ack", dta, 2);
        chk("t2 uart wmask", 32'(w1), 1);
        chk("t2 uart wdata", wdo, 32'h41);
        chk("t2 ram wmask", 32'(w0), 0);
        chk("t2 no rstrb", nrs, 0);

        // 3: both masters read continuously from reset, grants alternate
        do_reset();
        val[0][0] = 32'h1111_0000;
        val[0][1] = 32'h2222_0000;
        @(posedge clk); #1;
        set_req(0, 0, 32'h0000_0100, 1, 0, 0);
        set_req(0, 1, 32'h0040_0100, 1, 0, 0);
        t0 = cyc; n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++)
                if (ack_w[0][m]) begin
                    chk("t3 ack master", m, n % 2);
                    chk("t3 ack time", cyc - t0, 3 + 4 * n);
                    chk("t3 gnt", 32'(d_gnt[0]), m == 1 ? 2 : 1);
                    n++;
                end
        end
        chk("t3 ack count", n, 4);
        @(posedge clk); #1;
        drop(0, 0); drop(0, 1);
        chk("t3 m0 rdata", d_rd[0][0], 32'h1111_0000);
        chk("t3 m1 rdata", d_rd[0][1], 32'h2222_0000);

        // 4: rstrb together with wmask is a write
        xact(0, 0, 32'h0000_0020, 1, 4'hF, 32'h5555_AAAA, dti, dta, nrs, w0, w1, wdo);
        chk("t4 no rstrb", nrs, 0);
        chk("t4 ack", dta, 2);
        chk("t4 ram wmask", 32'(w0), 32'hF);
        chk("t4 rdata kept", d_rd[0][0], 32'h1111_0000);

        // 5: latency 3 instance, RAM then UART
        val[1][0] = 32'hCAFE_F00D;
        xact(1, 0, 32'h0000_0030, 1, 0, 0, dti, dta, nrs, w0, w1, wdo);
        chk("t5 issue", dti, 1);
        chk("t5 ack", dta, 5);
        chk("t5 rdata", d_rd[1][0], 32'hCAFE_F00D);
        val[1][1] = 32'h600D_D00D;
        xact(1, 1, 32'h0040_0004, 1, 0, 0, dti, dta, nrs, w0, w1, wdo);
        chk("t5 uart ack", dta, 5);
        chk("t5 uart rdata", d_rd[1][1], 32'h600D_D00D);
        chk("t5 m0 rdata kept", d_rd[1][0], 32'hCAFE_F00D);

        // 6: reset during WAIT of an M1 read
        val[0][1] = 32'h0000_0077;
        @(posedge clk); #1;
        set_req(0, 1, 32'h0040_0000, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk("t6 gnt", 32'(d_gnt[0]), 0);
        chk("t6 m1 ack", 32'(ack_w[0][1]), 0);
        chk("t6 ram addr", s_addr[0][0], 0);
        chk("t6 m1 rdata", d_rd[0][1], 0);
        drop(0, 1);
        @(posedge clk); #1 rst_n = 1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_w[0][1]) n++;
        end
        chk("t6 no late ack", n, 0);
        @(posedge clk); #1;
        set_req(0, 0, 32'h0000_0040, 0, 4'hF, 1);
        set_req(0, 1, 32'h0040_0040, 0, 4'h1, 2);
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            @(negedge clk);
            if (ack_w[0][0]) first = 0;
            else if (ack_w[0][1]) first = 1;
        end
        chk("t6 tie winner", first, 0);
        @(posedge clk); #1;
        drop(0, 0); drop(0, 1);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
